myproject_ln_scale_shift: RTL
=============================

// Module: myproject_ln_scale_shift
// PURPOSE
//  Layernorm output stage. Sits directly downstream of the 19s x 8u normalise multiplier.
//  Consumes its 27-bit signed product, (x - mean) * inv_std, as a valid/ready stream.
//  Per element: applies per-feature gamma scale and beta shift, rounds and saturates,
//    and emits the result with a last flag on the final element of each N_IN vector.
//  Gamma/beta live in a small register file written through a side port.
// PARAMETERS
//  N_IN        8   elements per layernorm vector; index counter wraps here (>=2)
//  PROD_WIDTH  27  input product width, signed
//  PROD_FRAC   18  fractional bits of the input product
//  GB_WIDTH    16  gamma/beta width, signed
//  GB_FRAC     10  fractional bits of gamma and beta
//  OUT_WIDTH   16  output width, signed
//  OUT_FRAC    10  fractional bits of the output (OUT_FRAC <= PROD_FRAC+GB_FRAC)
// PORTS
//  ap_clk     in   1               clock, rising edge
//  ap_rst_n   in   1               synchronous reset, active-low
//  in_data    in   PROD_WIDTH      normalised product from the multiplier
//  in_valid   in   1               in_data valid
//  in_ready   out  1               stage accepts in_data this cycle
//  gb_we      in   1               gamma/beta write strobe
//  gb_addr    in   clog2(N_IN)     feature index to write
//  gb_gamma   in   GB_WIDTH        gamma value
//  gb_beta    in   GB_WIDTH        beta value
//  out_data   out  OUT_WIDTH       scaled, shifted, saturated result
//  out_valid  out  1               out_data valid
//  out_ready  in   1               downstream accepts out_data
//  out_last   out  1               out_data is element N_IN-1 of its vector
// BEHAVIOUR
//  Reset (ap_rst_n==0 at edge):
//   - out_valid=0, out_data=0, out_last=0, all pipeline valids=0, index=0.
//   - every gamma = 1.0 (1<<GB_FRAC); every beta = 0.
//   - Mid-stream reset discards in-flight data; the next vector starts at index 0.
//  Pipeline: 3 stages, global stall.
//   - en = !out_valid | out_ready; in_ready = en (combinational).
//   - Input transfer when in_valid & in_ready. Transfer to output at out_valid & out_ready.
//   - Latency 3 cycles, accept to out_valid, with no stall. Throughput 1/cycle.
//   - While en==0, every stage register holds; out_data/out_last stay stable.
//  S1: register the product, the index, and gamma[index]/beta[index]; last = (index==N_IN-1).
//  S2: prod*gamma, full width PROD_WIDTH+GB_WIDTH signed, frac PROD_FRAC+GB_FRAC.
//  S3: add beta sign-extended and left-shifted by PROD_FRAC (the same frac).
//   - Round half-up: add 1<<(SH-1), then arithmetic shift right SH, where SH = PROD_FRAC+GB_FRAC-OUT_FRAC.
//   - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. No wrap ever.
//  Index counter: advances on each input transfer; N_IN-1 -> 0 wraps.
//  Gamma/beta writes:
//   - A write at edge t is visible to S1 lookups from edge t+1.
//   - A same-cycle S1 lookup of the same address reads the old value.
//   - Writes are accepted regardless of stall; gb_addr >= N_IN is ignored.
//  in_valid low: bubbles propagate; out_valid is low for the matching cycle.
// TESTING
//  1 gamma=1024, beta=0, in=262144 (1.0) -> out_data=1024 after 3 cycles, out_valid=1.
//  2 gamma=1024, beta=512, in=-65536 (-0.25) -> out_data=256.
//  3 Rounding, gamma=1024, beta=0: in=384 -> 2; in=-384 -> -1; in=128 -> 1; in=-128 -> 0.
//  4 Saturation, gamma=2048: in=2^26-1 -> 32767; in=-2^26 -> -32768.
//  5 Stream 3 vectors with N_IN=8 and random out_ready:
//     - out_last on every 8th output only; order preserved; no loss or duplication.
//     - out_data is stable while stalled; in_ready==(!out_valid|out_ready).
//  6 Write gamma[3]=512 mid-stream in the cycle element 3 is in S1 -> that element uses old gamma.
//     The next vector's element 3 is halved. Then reset mid-vector:
//     - out_valid=0 next cycle; gamma[3] reads back 1024.
//     - The next accepted element is index 0.

Source files
------------

// File: rtl/myproject_ln_scale_shift.sv
// Layernorm output stage: per-feature gamma scale, beta shift, round half-up,
// saturate. Three-stage valid/ready pipeline with a single global stall.
module myproject_ln_scale_shift #(
  parameter int N_IN       = 8,
  parameter int PROD_WIDTH = 27,
  parameter int PROD_FRAC  = 18,
  parameter int GB_WIDTH   = 16,
  parameter int GB_FRAC    = 10,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_FRAC   = 10,
  localparam int AW        = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         gb_we,
  input  logic        [AW-1:0]         gb_addr,
  input  logic signed [GB_WIDTH-1:0]   gb_gamma,
  input  logic signed [GB_WIDTH-1:0]   gb_beta,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int MUL_W = PROD_WIDTH + GB_WIDTH;
  // Two guard bits: the beta term and the rounding constant can each carry.
  localparam int SUM_W = MUL_W + 2;
  localparam int SH    = PROD_FRAC + GB_FRAC - OUT_FRAC;

  localparam logic [AW-1:0]              IDX_LAST  = AW'(N_IN - 1);
  localparam logic signed [GB_WIDTH-1:0] GAMMA_ONE = GB_WIDTH'(1 << GB_FRAC);
  localparam logic signed [SUM_W-1:0]    RND       =
    (SH > 0) ? (SUM_W'(1) <<< ((SH > 0) ? SH - 1 : 0)) : '0;
  localparam logic signed [SUM_W-1:0]    SAT_MAX   = (SUM_W'(1) <<< (OUT_WIDTH - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0]    SAT_MIN   = -SAT_MAX - SUM_W'(1);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX  = OUT_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN  = -OUT_MAX - OUT_WIDTH'(1);

  logic signed [GB_WIDTH-1:0]   r_gamma [N_IN];
  logic signed [GB_WIDTH-1:0]   r_beta  [N_IN];
  logic        [AW-1:0]         r_idx;

  logic                         r_s1_valid;
  logic signed [PROD_WIDTH-1:0] r_s1_prod;
  logic signed [GB_WIDTH-1:0]   r_s1_gamma;
  logic signed [GB_WIDTH-1:0]   r_s1_beta;
  logic                         r_s1_last;

  logic                         r_s2_valid;
  logic signed [MUL_W-1:0]      r_s2_mult;
  logic signed [GB_WIDTH-1:0]   r_s2_beta;
  logic                         r_s2_last;

  logic                         w_en;
  logic                         w_addr_ok;
  logic signed [SUM_W-1:0]      w_sum;
  logic signed [SUM_W-1:0]      w_shift;
  logic signed [OUT_WIDTH-1:0]  w_sat;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // An address range check is only needed when N_IN leaves unused codes.
  generate
    if ((1 << AW) == N_IN) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
      assign w_addr_ok = (int'(gb_addr) < N_IN);
    end
  endgenerate

  // Gamma/beta register file; writes land regardless of pipeline stall.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        r_gamma[i] <= GAMMA_ONE;
        r_beta[i]  <= '0;
      end
    end else if (gb_we && w_addr_ok) begin
      r_gamma[gb_addr] <= gb_gamma;
      r_beta[gb_addr]  <= gb_beta;
    end
  end

  // Stage 3 arithmetic: add shifted beta, round half-up, saturate.
  always_comb begin
    w_sum   = SUM_W'(r_s2_mult) + (SUM_W'(r_s2_beta) <<< PROD_FRAC) + RND;
    w_shift = w_sum >>> SH;
    w_sat   = w_shift[OUT_WIDTH-1:0];
    if (w_shift > SAT_MAX) begin
      w_sat = OUT_MAX;
    end else if (w_shift < SAT_MIN) begin
      w_sat = OUT_MIN;
    end
  end

  // Pipeline registers and element index; everything holds while stalled.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_gamma <= '0;
      r_s1_beta  <= '0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_mult  <= '0;
      r_s2_beta  <= '0;
      r_s2_last  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_prod  <= in_data;
      r_s1_gamma <= r_gamma[r_idx];
      r_s1_beta  <= r_beta[r_idx];
      r_s1_last  <= (r_idx == IDX_LAST);
      if (in_valid) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      r_s2_valid <= r_s1_valid;
      r_s2_mult  <= r_s1_prod * r_s1_gamma;
      r_s2_beta  <= r_s1_beta;
      r_s2_last  <= r_s1_last;

      out_valid  <= r_s2_valid;
      out_data   <= w_sat;
      out_last   <= r_s2_last && r_s2_valid;
    end
  end

endmodule
